// File: rtl/dcache_ctrl_pkg.sv
// Shared data-cache definitions: memory command encodings, cache geometry and
// store-buffer depth, plus the controller state type and address helpers.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH
`define MEM_CMD_NONE    2'd0
`define MEM_CMD_LOAD    2'd1
`define MEM_CMD_STORE   2'd2
`define DCACHE_LINES    32
`define DCACHE_IDX_BITS 5
`define DCACHE_TAG_BITS 56
`define DCACHE_SB_DEPTH 4
`endif

package dcache_ctrl_pkg;

  localparam int unsigned LINES       = `DCACHE_LINES;
  localparam int unsigned IDX_BITS    = `DCACHE_IDX_BITS;
  localparam int unsigned TAG_BITS    = `DCACHE_TAG_BITS;
  localparam int unsigned SB_DEPTH    = `DCACHE_SB_DEPTH;
  localparam int unsigned SB_PTR_BITS = $clog2(SB_DEPTH);
  localparam int unsigned SB_CNT_BITS = SB_PTR_BITS + 1;

  typedef enum logic [1:0] {
    CMD_NONE  = `MEM_CMD_NONE,
    CMD_LOAD  = `MEM_CMD_LOAD,
    CMD_STORE = `MEM_CMD_STORE
  } mem_cmd_e;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    MISS_WAIT,
    MISS_DONE
  } dc_state_e;

  // Lines are 8 bytes wide, so the index starts just above the byte offset.
  function automatic logic [IDX_BITS-1:0] addr_idx(input logic [63:0] addr);
    return addr[IDX_BITS+2:3];
  endfunction

  function automatic logic [TAG_BITS-1:0] addr_tag(input logic [63:0] addr);
    return addr[63:IDX_BITS+3];
  endfunction

endpackage

// File: rtl/dcache_stbuf.sv
// Retired-store FIFO feeding memory writes; also forwards the youngest
// matching entry to loads.
module dcache_stbuf
  import dcache_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [63:0] push_addr,
  input  logic [63:0] push_data,
  input  logic        pop,
  output logic [63:0] head_addr,
  output logic [63:0] head_data,
  input  logic [63:0] lookup_addr,
  output logic        match,
  output logic [63:0] match_data,
  output logic        full,
  output logic        empty
);

  logic [63:0]            addr_q [SB_DEPTH];
  logic [63:0]            data_q [SB_DEPTH];
  logic [SB_PTR_BITS-1:0] head;
  logic [SB_PTR_BITS-1:0] tail;
  logic [SB_CNT_BITS-1:0] count;
  logic                   push_ok;
  logic                   pop_ok;

  assign full    = (count == SB_CNT_BITS'(SB_DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // When full, a push only fits if the head leaves in the same cycle.
  assign push_ok = push && (!full || pop_ok);

  assign head_addr = addr_q[head];
  assign head_data = data_q[head];

  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + 1'b1;
      if (pop_ok)  head <= head + 1'b1;
      count <= count + SB_CNT_BITS'(push_ok) - SB_CNT_BITS'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) begin
      addr_q[tail] <= push_addr;
      data_q[tail] <= push_data;
    end
  end

  // Walk oldest to youngest so the last hit is the youngest store.
  always_comb begin
    logic [SB_PTR_BITS-1:0] slot;
    slot       = '0;
    match      = 1'b0;
    match_data = '0;
    for (int unsigned k = 0; k < SB_DEPTH; k++) begin
      slot = head + SB_PTR_BITS'(k);
      if ((SB_CNT_BITS'(k) < count) && (addr_q[slot] == lookup_addr)) begin
        match      = 1'b1;
        match_data = data_q[slot];
      end
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-through data cache with a blocking single-miss FSM and
// a store buffer that drains to memory whenever the port is free.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        Dcache_rd_mem,
  input  logic [63:0] Dcache_addr,
  input  logic [6:0]  Dcache_pr_idx,
  input  logic [4:0]  Dcache_ar_idx,
  input  logic        Dcache_wr_mem,
  input  logic [63:0] Dcache_st_addr,
  input  logic [63:0] Dcache_st_value,
  input  logic [3:0]  mem2proc_response,
  input  logic [63:0] mem2proc_data,
  input  logic [3:0]  mem2proc_tag,
  output logic        Dcache_avail,
  output logic        Dcache_st_full,
  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,
  output logic        cdb_complete,
  output logic        prf_pr_wr_enable,
  output logic [6:0]  cdb_prf_pr_idx,
  output logic [4:0]  cdb_ar_idx,
  output logic [63:0] prf_pr_value
);

  dc_state_e state, next_state;

  logic [63:0]         line_data [LINES];
  logic [TAG_BITS-1:0] line_tag  [LINES];
  logic [LINES-1:0]    line_valid;

  logic [63:0] miss_addr;
  logic [6:0]  miss_pr;
  logic [4:0]  miss_ar;
  logic [3:0]  miss_mtag;
  logic        install_block;

  logic        sb_pop, sb_full, sb_empty, sb_match;
  logic [63:0] sb_head_addr, sb_head_data, sb_match_data;

  logic [IDX_BITS-1:0] ld_idx, st_idx, miss_idx;
  logic load_go, cache_hit, load_hit, load_miss;
  logic st_accept, st_line_hit, st_to_miss, tag_return, install;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{Dcache_addr[2:0], Dcache_st_addr[2:0]};

  assign ld_idx   = addr_idx(Dcache_addr);
  assign st_idx   = addr_idx(Dcache_st_addr);
  assign miss_idx = addr_idx(miss_addr);

  assign load_go   = Dcache_rd_mem && (state == IDLE);
  assign cache_hit = line_valid[ld_idx] && (line_tag[ld_idx] == addr_tag(Dcache_addr));
  assign load_hit  = load_go && (sb_match || cache_hit);
  assign load_miss = load_go && !load_hit;

  assign st_accept   = Dcache_wr_mem && (!sb_full || sb_pop);
  assign st_line_hit = st_accept && line_valid[st_idx] &&
                       (line_tag[st_idx] == addr_tag(Dcache_st_addr));
  assign st_to_miss  = st_accept && (Dcache_st_addr == miss_addr);
  assign tag_return  = (state == MISS_WAIT) && (mem2proc_tag != '0) &&
                       (mem2proc_tag == miss_mtag);
  // Memory data for a miss predates any store that overtook it; installing it
  // would leave a stale line behind once that store drains.
  assign install     = (state == MISS_DONE) && !install_block && !st_to_miss;

  assign Dcache_st_full   = sb_full;
  assign prf_pr_wr_enable = cdb_complete;

  dcache_stbuf u_stbuf (
    .clock       (clock),
    .reset       (reset),
    .push        (Dcache_wr_mem),
    .push_addr   (Dcache_st_addr),
    .push_data   (Dcache_st_value),
    .pop         (sb_pop),
    .head_addr   (sb_head_addr),
    .head_data   (sb_head_data),
    .lookup_addr (Dcache_addr),
    .match       (sb_match),
    .match_data  (sb_match_data),
    .full        (sb_full),
    .empty       (sb_empty)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (load_miss) next_state = MISS_REQ;
      MISS_REQ:  if (mem2proc_response != '0) next_state = MISS_WAIT;
      MISS_WAIT: if (tag_return) next_state = MISS_DONE;
      MISS_DONE: next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  always_comb begin
    Dcache_avail     = (state == IDLE);
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    sb_pop           = 1'b0;
    if (state == MISS_REQ) begin
      proc2mem_command = CMD_LOAD;
      proc2mem_addr    = miss_addr;
    end else if (((state == IDLE) || (state == MISS_WAIT)) && !sb_empty) begin
      proc2mem_command = CMD_STORE;
      proc2mem_addr    = sb_head_addr;
      proc2mem_data    = sb_head_data;
      sb_pop           = (mem2proc_response != '0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      line_valid     <= '0;
      cdb_complete   <= 1'b0;
      cdb_prf_pr_idx <= '0;
      cdb_ar_idx     <= '0;
      prf_pr_value   <= '0;
      miss_addr      <= '0;
      miss_pr        <= '0;
      miss_ar        <= '0;
      miss_mtag      <= '0;
      install_block  <= 1'b0;
    end else begin
      cdb_complete <= 1'b0;
      if (load_hit) begin
        cdb_complete   <= 1'b1;
        cdb_prf_pr_idx <= Dcache_pr_idx;
        cdb_ar_idx     <= Dcache_ar_idx;
        prf_pr_value   <= sb_match ? sb_match_data : line_data[ld_idx];
      end
      if (load_miss) begin
        miss_addr     <= Dcache_addr;
        miss_pr       <= Dcache_pr_idx;
        miss_ar       <= Dcache_ar_idx;
        install_block <= st_accept && (Dcache_st_addr == Dcache_addr);
      end else if ((state != IDLE) && st_to_miss) begin
        install_block <= 1'b1;
      end
      if ((state == MISS_REQ) && (mem2proc_response != '0))
        miss_mtag <= mem2proc_response;
      // Broadcast is registered here so it lines up with the MISS_DONE cycle.
      if (tag_return) begin
        cdb_complete   <= 1'b1;
        cdb_prf_pr_idx <= miss_pr;
        cdb_ar_idx     <= miss_ar;
        prf_pr_value   <= mem2proc_data;
      end
      if (install) line_valid[miss_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (st_line_hit) line_data[st_idx] <= Dcache_st_value;
    if (install) begin
      line_data[miss_idx] <= prf_pr_value;
      line_tag[miss_idx]  <= addr_tag(miss_addr);
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: miss/hit, store forwarding, buffer fill and
// wrap, store-during-miss install suppression, and reset during a miss.
module tb_dcache_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        Dcache_rd_mem;
  logic [63:0] Dcache_addr;
  logic [6:0]  Dcache_pr_idx;
  logic [4:0]  Dcache_ar_idx;
  logic        Dcache_wr_mem;
  logic [63:0] Dcache_st_addr;
  logic [63:0] Dcache_st_value;
  logic [3:0]  mem2proc_response;
  logic [63:0] mem2proc_data;
  logic [3:0]  mem2proc_tag;
  logic        Dcache_avail;
  logic        Dcache_st_full;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic        cdb_complete;
  logic        prf_pr_wr_enable;
  logic [6:0]  cdb_prf_pr_idx;
  logic [4:0]  cdb_ar_idx;
  logic [63:0] prf_pr_value;

  int n_cmp = 0;
  int n_bad = 0;

  dcache_ctrl dut (
    .clock             (clock),
    .reset             (reset),
    .Dcache_rd_mem     (Dcache_rd_mem),
    .Dcache_addr       (Dcache_addr),
    .Dcache_pr_idx     (Dcache_pr_idx),
    .Dcache_ar_idx     (Dcache_ar_idx),
    .Dcache_wr_mem     (Dcache_wr_mem),
    .Dcache_st_addr    (Dcache_st_addr),
    .Dcache_st_value   (Dcache_st_value),
    .mem2proc_response (mem2proc_response),
    .mem2proc_data     (mem2proc_data),
    .mem2proc_tag      (mem2proc_tag),
    .Dcache_avail      (Dcache_avail),
    .Dcache_st_full    (Dcache_st_full),
    .proc2mem_command  (proc2mem_command),
    .proc2mem_addr     (proc2mem_addr),
    .proc2mem_data     (proc2mem_data),
    .cdb_complete      (cdb_complete),
    .prf_pr_wr_enable  (prf_pr_wr_enable),
    .cdb_prf_pr_idx    (cdb_prf_pr_idx),
    .cdb_ar_idx        (cdb_ar_idx),
    .prf_pr_value      (prf_pr_value)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    Dcache_rd_mem = 0; Dcache_addr = '0; Dcache_pr_idx = '0; Dcache_ar_idx = '0;
    Dcache_wr_mem = 0; Dcache_st_addr = '0; Dcache_st_value = '0;
    mem2proc_response = '0; mem2proc_data = '0; mem2proc_tag = '0;
    #1;
    do_reset();

    check("rst_avail", 64'(Dcache_avail), 64'd1);
    check("rst_cdb",   64'(cdb_complete), 64'd0);
    check("rst_wren",  64'(prf_pr_wr_enable), 64'd0);
    check("rst_cmd",   64'(proc2mem_command), 64'd0);
    check("rst_full",  64'(Dcache_st_full), 64'd0);

    // Cold miss on 0x100
    Dcache_rd_mem = 1; Dcache_addr = 64'h100; Dcache_pr_idx = 7'd5; Dcache_ar_idx = 5'd3;
    tick();
    Dcache_rd_mem = 0;
    check("miss_avail", 64'(Dcache_avail), 64'd0);
    check("miss_cmd",   64'(proc2mem_command), 64'd1);
    check("miss_addr",  proc2mem_addr, 64'h100);
    tick();
    check("miss_retry_cmd", 64'(proc2mem_command), 64'd1);
    mem2proc_response = 4'd3;
    tick();
    mem2proc_response = 4'd0;
    check("wait_cmd", 64'(proc2mem_command), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("wait_avail", 64'(Dcache_avail), 64'd0);
      check("wait_cdb",   64'(cdb_complete), 64'd0);
      tick();
    end
    mem2proc_tag = 4'd2; mem2proc_data = 64'hDEAD;
    tick();
    check("wrongtag_cdb", 64'(cdb_complete), 64'd0);
    mem2proc_tag = 4'd3; mem2proc_data = 64'hAB;
    tick();
    mem2proc_tag = 4'd0; mem2proc_data = '0;
    check("fill_cdb",   64'(cdb_complete), 64'd1);
    check("fill_wren",  64'(prf_pr_wr_enable), 64'd1);
    check("fill_pr",    64'(cdb_prf_pr_idx), 64'd5);
    check("fill_ar",    64'(cdb_ar_idx), 64'd3);
    check("fill_val",   prf_pr_value, 64'hAB);
    check("fill_avail", 64'(Dcache_avail), 64'd0);
    tick();
    check("fill_pulse_end", 64'(cdb_complete), 64'd0);
    check("fill_idle",      64'(Dcache_avail), 64'd1);

    // Repeat load hits
    Dcache_rd_mem = 1; Dcache_addr = 64'h100; Dcache_pr_idx = 7'd6; Dcache_ar_idx = 5'd4;
    check("hit_nocmd", 64'(proc2mem_command), 64'd0);
    tick();
    Dcache_rd_mem = 0;
    check("hit_cdb", 64'(cdb_complete), 64'd1);
    check("hit_pr",  64'(cdb_prf_pr_idx), 64'd6);
    check("hit_ar",  64'(cdb_ar_idx), 64'd4);
    check("hit_val", prf_pr_value, 64'hAB);
    check("hit_nocmd2", 64'(proc2mem_command), 64'd0);
    tick();
    check("hit_pulse_end", 64'(cdb_complete), 64'd0);

    // Same-cycle load hit and store: load sees pre-store value
    Dcache_rd_mem = 1; Dcache_pr_idx = 7'd7; Dcache_ar_idx = 5'd2;
    Dcache_wr_mem = 1; Dcache_st_addr = 64'h100; Dcache_st_value = 64'h55;
    tick();
    Dcache_rd_mem = 0; Dcache_wr_mem = 0;
    check("samecyc_val", prf_pr_value, 64'hAB);
    check("st_cmd",  64'(proc2mem_command), 64'd2);
    check("st_addr", proc2mem_addr, 64'h100);
    check("st_data", proc2mem_data, 64'h55);
    Dcache_rd_mem = 1; Dcache_pr_idx = 7'd8;
    tick();
    Dcache_rd_mem = 0;
    check("fwd_cdb", 64'(cdb_complete), 64'd1);
    check("fwd_val", prf_pr_value, 64'h55);
    mem2proc_response = 4'd1;
    tick();
    mem2proc_response = 4'd0;
    check("drained_cmd", 64'(proc2mem_command), 64'd0);

    // Fill buffer with memory rejecting
    for (int i = 0; i < 4; i++) begin
      Dcache_wr_mem = 1; Dcache_st_addr = 64'h200 + 64'(8 * i); Dcache_st_value = 64'(i + 1);
      tick();
    end
    check("full_set", 64'(Dcache_st_full), 64'd1);
    Dcache_st_addr = 64'h220; Dcache_st_value = 64'h99;
    tick();
    check("drop_full", 64'(Dcache_st_full), 64'd1);
    check("drop_head", proc2mem_addr, 64'h200);
    check("drop_data", proc2mem_data, 64'd1);
    Dcache_st_addr = 64'h228; Dcache_st_value = 64'h77; mem2proc_response = 4'd2;
    tick();
    Dcache_wr_mem = 0;
    check("pushpop_full", 64'(Dcache_st_full), 64'd1);
    check("pushpop_head", proc2mem_addr, 64'h208);
    tick();
    check("pop_clears_full", 64'(Dcache_st_full), 64'd0);
    check("wrap_head1", proc2mem_addr, 64'h210);
    tick();
    check("wrap_head2", proc2mem_addr, 64'h218);
    tick();
    check("wrap_head3", proc2mem_addr, 64'h228);
    check("wrap_data3", proc2mem_data, 64'h77);
    tick();
    mem2proc_response = 4'd0;
    check("empty_cmd", 64'(proc2mem_command), 64'd0);

    // Store to the missing address while the miss is outstanding
    do_reset();
    Dcache_rd_mem = 1; Dcache_addr = 64'h100; Dcache_pr_idx = 7'd9; Dcache_ar_idx = 5'd1;
    tick();
    Dcache_rd_mem = 0; mem2proc_response = 4'd2;
    tick();
    mem2proc_response = 4'd0;
    Dcache_wr_mem = 1; Dcache_st_addr = 64'h100; Dcache_st_value = 64'h55;
    tick();
    Dcache_wr_mem = 0;
    check("mw_store_cmd",  64'(proc2mem_command), 64'd2);
    check("mw_store_addr", proc2mem_addr, 64'h100);
    mem2proc_tag = 4'd2; mem2proc_data = 64'h77;
    tick();
    mem2proc_tag = 4'd0;
    check("race_cdb", 64'(cdb_complete), 64'd1);
    check("race_pr",  64'(cdb_prf_pr_idx), 64'd9);
    check("race_val", prf_pr_value, 64'h77);
    tick();
    Dcache_rd_mem = 1; Dcache_pr_idx = 7'd10;
    tick();
    Dcache_rd_mem = 0;
    check("race_fwd_val", prf_pr_value, 64'h55);
    mem2proc_response = 4'd1;
    tick();
    mem2proc_response = 4'd0;
    Dcache_rd_mem = 1; Dcache_pr_idx = 7'd11;
    tick();
    Dcache_rd_mem = 0;
    check("nostale_cdb",   64'(cdb_complete), 64'd0);
    check("nostale_avail", 64'(Dcache_avail), 64'd0);
    check("nostale_cmd",   64'(proc2mem_command), 64'd1);
    mem2proc_response = 4'd4;
    tick();
    mem2proc_response = 4'd0; mem2proc_tag = 4'd4; mem2proc_data = 64'h55;
    tick();
    mem2proc_tag = 4'd0;
    check("refill_val", prf_pr_value, 64'h55);
    check("refill_pr",  64'(cdb_prf_pr_idx), 64'd11);
    tick();

    // Reset during MISS_WAIT abandons the miss
    Dcache_rd_mem = 1; Dcache_addr = 64'h400; Dcache_pr_idx = 7'd12;
    tick();
    Dcache_rd_mem = 0; mem2proc_response = 4'd5;
    tick();
    mem2proc_response = 4'd0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstmiss_avail", 64'(Dcache_avail), 64'd1);
    mem2proc_tag = 4'd5; mem2proc_data = 64'h99;
    tick();
    mem2proc_tag = 4'd0;
    check("rstmiss_cdb",   64'(cdb_complete), 64'd0);
    check("rstmiss_avail2", 64'(Dcache_avail), 64'd1);
    check("rstmiss_cmd",   64'(proc2mem_command), 64'd0);
    tick();
    check("rstmiss_cdb2",  64'(cdb_complete), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state updates on posedge clock.
REQ-002 clock  in  1  system clock.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 Dcache_rd_mem  in  1  load request valid from LSQ.
REQ-005 Dcache_addr  in  64  load byte address (8-byte aligned).
REQ-006 Dcache_pr_idx  in  7  load destination physical reg.
REQ-007 Dcache_ar_idx  in  5  load destination arch reg.
REQ-008 Dcache_wr_mem  in  1  retired store valid.
REQ-009 Dcache_st_addr  in  64  retired store address.
REQ-010 Dcache_st_value  in  64  retired store data.
REQ-011 mem2proc_response  in  4  memory accept tag; 0 = rejected.
REQ-012 mem2proc_data  in  64  memory return data.
REQ-013 mem2proc_tag  in  4  tag of returning data; 0 = none.
REQ-014 Dcache_avail  out  1  load request will be accepted this cycle.
REQ-015 Dcache_st_full  out  1  store buffer full.
REQ-016 proc2mem_command  out  2  NONE=0, LOAD=1, STORE=2.
REQ-017 proc2mem_addr  out  64  memory address.
REQ-018 proc2mem_data  out  64  store data to memory.
REQ-019 cdb_complete, prf_pr_wr_enable  out  1 each  load result valid.
REQ-020 cdb_prf_pr_idx / cdb_ar_idx / prf_pr_value  out  7/5/64  load result.

Function
REQ-021 Cache: direct-mapped, 32 lines x 64 bits; index = addr[7:3], tag = addr[63:8], per-line valid bit.
REQ-022 Store buffer: 4-entry FIFO (addr, data), 2-bit head/tail plus 3-bit count.
REQ-023 FSM states IDLE, MISS_REQ, MISS_WAIT, MISS_DONE.
REQ-024 Dcache_avail = (state==IDLE); a load with Dcache_rd_mem while Dcache_avail=0 is ignored.
REQ-025 Load accepted in IDLE: youngest store-buffer address match gives hit with buffer data; else valid cache tag match gives hit with line data; else miss.
REQ-026 Hit: result registered, cdb_complete/prf_pr_wr_enable high exactly one cycle after request, carrying the request's pr/ar indices.
REQ-027 Miss: latch addr/pr/ar; IDLE->MISS_REQ.
REQ-028 MISS_REQ: drive LOAD/addr every cycle; nonzero mem2proc_response latches tag and moves to MISS_WAIT; zero response retries next cycle.
REQ-029 MISS_WAIT: mem2proc_tag equal to latched tag latches data, ->MISS_DONE.
REQ-030 MISS_DONE: one-cycle result broadcast with returned data; install line (valid=1) unless a store to the same address entered the buffer during the miss; ->IDLE.
REQ-031 Store with Dcache_wr_mem pushes to buffer the same cycle; on cache tag hit the line is updated (write-through, no-allocate).
REQ-032 Buffer drain: when state is IDLE or MISS_WAIT and buffer non-empty, drive STORE with head entry; pop on nonzero response, else retry.
REQ-033 MISS_REQ owns the memory port; no store is driven there.
REQ-034 Dcache_st_full = (count==4); a push while full with no same-cycle pop is dropped (protocol error). Simultaneous push and pop when full is legal; count unchanged.
REQ-035 Pointers wrap modulo 4.
REQ-036 Load hit and store to the same address in one cycle: load returns pre-store value.
REQ-037 No output is driven by combinational paths from mem2proc_* except proc2mem_*.

Reset
REQ-038 Reset SHALL clear all valid bits, empty the buffer, state=IDLE; all outputs 0 except Dcache_avail=1 the cycle after reset.
REQ-039 Reset during a miss SHALL abandon it; a later matching mem2proc_tag is ignored.

Structure
REQ-040 Command encodings, cache geometry (lines, index/tag bits) and buffer depth SHALL be `define constants in the shared sys_defs header.
REQ-041 Store buffer SHALL be one sub-module, dcache_stbuf (push, pop, head, match lookup, full/empty).

Verification
REQ-042 Cold load 0x100, response 3, tag 3 after 5 cycles with data 0xAB -> single cdb pulse pr/value=0xAB; avail low throughout miss.
REQ-043 Repeat load 0x100 -> hit, cdb one cycle later, no memory command.
REQ-044 Store 0x100=0x55, then load 0x100 before drain -> forwarded 0x55; STORE command observed afterwards.
REQ-045 Four stores with memory rejecting -> st_full=1; first accept pops, full clears.
REQ-046 Miss outstanding, store to same address arrives -> load returns memory data; next load 0x100 misses or forwards 0x55, never stale line.
REQ-047 Reset in MISS_WAIT, then tag returns -> no cdb pulse, avail=1.
